// File: rtl/gate_pkg.sv
// Shared types and the golden truth function for the 2-input gate checker.
package gate_pkg;

  typedef enum logic [2:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_NOT     = 3'd2,
    OP_XOR     = 3'd3,
    OP_NAND    = 3'd4,
    OP_NOR     = 3'd5,
    OP_XNOR    = 3'd6,
    OP_ILLEGAL = 3'd7
  } gate_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } chk_state_e;

  localparam int NUM_VEC     = 4;
  localparam int NUM_VEC_NOT = 2;

  function automatic logic gate_expected(gate_op_e op, logic a, logic b);
    logic y;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference output for the selected gate; zero latency, no flow control.
module gate_ref_model
  import gate_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       y_o
);

  assign y_o = gate_expected(gate_op_e'(op_i), a_i, b_i);

endmodule

// File: rtl/gate_vector_checker.sv
// Exhaustive truth-table exerciser for a 2-input gate under test.
// Each vector takes SETTLE_CYCLES+2 cycles; start is only honoured in IDLE.
module gate_vector_checker
  import gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  localparam logic [3:0]       SETTLE_INIT = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  chk_state_e       state_q, state_d;
  gate_op_e         op_q, op_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [1:0]       fail_vec_q, fail_vec_d;
  logic             pass_q, pass_d;

  logic [1:0] cur_vec;
  logic       last_vec;
  logic       exp_y;
  logic       driving;

  // NOT walks only A (0,1) with B parked low.
  assign cur_vec  = (op_q == OP_NOT) ? {idx_q[0], 1'b0} : idx_q;
  assign last_vec = (op_q == OP_NOT) ? (idx_q == 2'(NUM_VEC_NOT - 1))
                                     : (idx_q == 2'(NUM_VEC - 1));

  gate_ref_model u_ref (
    .op_i (op_q),
    .a_i  (cur_vec[1]),
    .b_i  (cur_vec[0]),
    .y_o  (exp_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_AND;
      idx_q        <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      pass_q       <= pass_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    pass_d       = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d         = gate_op_e'(op);
          idx_d        = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          pass_d       = 1'b0;
          state_d      = (gate_op_e'(op) == OP_ILLEGAL) ? ST_DONE : ST_APPLY;
        end
      end
      ST_APPLY: begin
        cnt_d   = SETTLE_INIT;
        state_d = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) state_d = ST_CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_CHECK: begin
        if (dut_y != exp_y) begin
          if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = cur_vec;
          end
        end
        // Only legal ops reach CHECK, so pass reduces to a clean error count.
        if (last_vec) begin
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_APPLY;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign driving    = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign dut_a      = driving & cur_vec[1];
  assign dut_b      = driving & cur_vec[0];
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed-vector bench: a selectable behavioural GUT feeds dut_y from dut_a/dut_b.
module tb_gate_vector_checker;
  import gate_pkg::*;

  localparam int ERR_W = 2;
  localparam int TMO   = 200;

  localparam int G_AND  = 0;
  localparam int G_OR   = 1;
  localparam int G_NOT  = 2;
  localparam int G_NAND = 3;
  localparam int G_TIE0 = 4;
  localparam int G_TIE1 = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op = 3'd0;
  logic             dut_a, dut_b, dut_y;
  logic             busy, done, pass, fail_valid;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       fail_vec;
  int               gut_sel = G_AND;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (gut_sel)
      G_AND:   dut_y = dut_a & dut_b;
      G_OR:    dut_y = dut_a | dut_b;
      G_NOT:   dut_y = ~dut_a;
      G_NAND:  dut_y = ~(dut_a & dut_b);
      G_TIE1:  dut_y = 1'b1;
      default: dut_y = 1'b0;
    endcase
  end

  gate_vector_checker #(.SETTLE_CYCLES(2), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .dut_a      (dut_a),
    .dut_b      (dut_b),
    .dut_y      (dut_y),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_vec   (fail_vec)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] all_outs();
    return {dut_a, dut_b, busy, done, pass, err_count, fail_valid, fail_vec};
  endfunction

  // Issue start, then count edges after the accepting edge until done is seen.
  task automatic run_case(input string tag, input logic [2:0] op_v, input int gut,
                          input int ecyc, input logic epass, input int eerr,
                          input logic efv, input logic [1:0] efvec, input bit glitch);
    int   k;
    logic maxb;
    gut_sel = gut;
    @(negedge clk);
    op    = op_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k     = 0;
    maxb  = 1'b0;
    while (!done && k < TMO) begin
      maxb = maxb | dut_b;
      if (glitch && k == 3) begin
        start = 1'b1;
        op    = 3'd7;
      end else if (glitch && k == 5) begin
        start = 1'b0;
        op    = 3'd2;
      end
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_cycles"}, 32'(k), 32'(ecyc));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    chk({tag, "_pass"}, 32'(pass), 32'(epass));
    chk({tag, "_err"}, 32'(err_count), 32'(eerr));
    chk({tag, "_fail_valid"}, 32'(fail_valid), 32'(efv));
    chk({tag, "_fail_vec"}, 32'(fail_vec), 32'(efvec));
    if (op_v == 3'd2) chk({tag, "_b_low"}, 32'(maxb), 32'd0);
    @(negedge clk);
    chk({tag, "_after"}, {27'd0, busy, done, pass, 2'(err_count)},
        {27'd0, 1'b0, 1'b0, epass, 2'(eerr)});
  endtask

  initial begin
    int k;
    #1;
    chk("reset_outs", 32'(all_outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_case("and",      3'd0, G_AND,  16, 1'b1, 0, 1'b0, 2'b00, 1'b0);
    run_case("xor_or",   3'd3, G_OR,   16, 1'b0, 1, 1'b1, 2'b11, 1'b0);
    run_case("not",      3'd2, G_NOT,   8, 1'b1, 0, 1'b0, 2'b00, 1'b0);
    run_case("not_tie1", 3'd2, G_TIE1,  8, 1'b0, 1, 1'b1, 2'b10, 1'b0);
    run_case("nand_t0",  3'd4, G_TIE0, 16, 1'b0, 3, 1'b1, 2'b00, 1'b0);
    run_case("xnor_t1",  3'd6, G_TIE1, 16, 1'b0, 2, 1'b1, 2'b01, 1'b0);
    run_case("and_sat",  3'd0, G_NAND, 16, 1'b0, 3, 1'b1, 2'b00, 1'b0);
    run_case("illegal",  3'd7, G_AND,   0, 1'b0, 0, 1'b0, 2'b00, 1'b0);
    run_case("glitch",   3'd0, G_AND,  16, 1'b1, 0, 1'b0, 2'b00, 1'b1);

    // start held through DONE: ignored there, accepted the cycle after.
    gut_sel = G_AND;
    @(negedge clk);
    op    = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < TMO) begin
      @(negedge clk);
      k++;
    end
    chk("hold_first_done", 32'(done), 32'd1);
    start = 1'b1;
    op    = 3'd7;
    @(negedge clk);
    chk("hold_in_done_ign", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    chk("hold_next_acc", {30'd0, busy, done}, 32'd3);
    chk("hold_next_pass", 32'(pass), 32'd0);
    start = 1'b0;
    @(negedge clk);

    // Reset during SETTLE of vector 2 ({A,B}=10).
    @(negedge clk);
    op    = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("rst_pre_vec", {29'd0, busy, dut_a, dut_b}, 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", 32'(all_outs()), 32'd0);
    k = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) k++;
    end
    chk("rst_no_done", 32'(k), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_case("post_rst", 3'd0, G_AND, 16, 1'b1, 0, 1'b0, 2'b00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
